// File: rtl/pad_cfg_sequencer.sv
// Break-before-make pad electrical config sequencer for NUM_PADS I/O pads.
// Optional per-pad write lock: define PAD_CFG_LOCK_EN.
module pad_cfg_sequencer #(
  parameter int NUM_PADS      = 32,
  parameter int SETTLE_CYCLES = 4,
  localparam int IDX_W        = $clog2(NUM_PADS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_req_i,
  output logic                  cfg_gnt_o,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic [5:0]            cfg_wdata_i,
`ifdef PAD_CFG_LOCK_EN
  input  logic                  cfg_lock_i,
`endif
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  output logic                  busy_o,
  input  logic [NUM_PADS-1:0]   periph_oen_i,
  output logic [NUM_PADS-1:0]   pad_oen_o,
  output logic [2*NUM_PADS-1:0] pad_drv_o,
  output logic [NUM_PADS-1:0]   pad_puen_o,
  output logic [NUM_PADS-1:0]   pad_slw_o,
  output logic [NUM_PADS-1:0]   pad_smt_o
);

  localparam int CNT_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W:0] NP_L = (IDX_W+1)'(NUM_PADS);

  typedef enum logic [1:0] {
    IDLE, ISOLATE, SETTLE, RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [5:0]       wdata_q;
  logic [5:0]       cfg_q [NUM_PADS];
  logic             done_q, err_q;
  logic             done_d, err_d;
  logic             accept, reject, same, cfg_we;
  logic             isolating;

  assign accept    = cfg_req_i && (state_q == IDLE);
  assign same      = (cfg_q[cfg_idx_i] == cfg_wdata_i);
  assign isolating = (state_q == ISOLATE) || (state_q == SETTLE);

`ifdef PAD_CFG_LOCK_EN
  logic [NUM_PADS-1:0] lock_q;
  logic                lock_lat_q;
  logic                lock_set;
  logic [IDX_W-1:0]    lock_idx;

  assign reject = ({1'b0, cfg_idx_i} >= NP_L) || lock_q[cfg_idx_i];
`else
  assign reject = ({1'b0, cfg_idx_i} >= NP_L);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cfg_we  = 1'b0;
`ifdef PAD_CFG_LOCK_EN
    lock_set = 1'b0;
    lock_idx = idx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else if (same) begin
            // Nothing to change: complete without isolating the pad
            done_d = 1'b1;
`ifdef PAD_CFG_LOCK_EN
            lock_set = cfg_lock_i;
            lock_idx = cfg_idx_i;
`endif
          end else begin
            state_d = ISOLATE;
          end
        end
      end
      ISOLATE: begin
        state_d = SETTLE;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        cfg_we  = 1'b1;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          done_d  = 1'b1;
`ifdef PAD_CFG_LOCK_EN
          lock_set = lock_lat_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_PADS; k++) begin
        cfg_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        idx_q   <= cfg_idx_i;
        wdata_q <= cfg_wdata_i;
      end
      if (cfg_we) begin
        cfg_q[idx_q] <= wdata_q;
      end
    end
  end

`ifdef PAD_CFG_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= '0;
      lock_lat_q <= 1'b0;
    end else begin
      if (accept) begin
        lock_lat_q <= cfg_lock_i;
      end
      if (lock_set) begin
        lock_q[lock_idx] <= 1'b1;
      end
    end
  end
`endif

  assign cfg_gnt_o  = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign cfg_done_o = done_q;
  assign cfg_err_o  = err_q;

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    logic iso;
    assign iso = isolating && (idx_q == IDX_W'(k));
    assign pad_drv_o[2*k +: 2] = cfg_q[k][5:4];
    assign pad_smt_o[k]  = cfg_q[k][3];
    assign pad_slw_o[k]  = cfg_q[k][2];
    assign pad_puen_o[k] = cfg_q[k][1];
    assign pad_oen_o[k]  =
      (iso || !cfg_q[k][0]) ? 1'b1 : periph_oen_i[k];
  end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Bench for pad_cfg_sequencer: directed steps plus randomized writes
// checked against a per-pad behavioural model.
module tb_pad_cfg_sequencer;

  localparam int NP = 20;
  localparam int S  = 4;
  localparam int IW = $clog2(NP);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic            cfg_req_i = 1'b0;
  logic            cfg_gnt_o;
  logic [IW-1:0]   cfg_idx_i = '0;
  logic [5:0]      cfg_wdata_i = '0;
`ifdef PAD_CFG_LOCK_EN
  logic            cfg_lock_i = 1'b0;
`endif
  logic            cfg_done_o, cfg_err_o, busy_o;
  logic [NP-1:0]   periph_oen_i = '0;
  logic [NP-1:0]   pad_oen_o, pad_puen_o, pad_slw_o, pad_smt_o;
  logic [2*NP-1:0] pad_drv_o;

  int   vectors = 0;
  int   miscompares = 0;
  logic [5:0] mcfg [NP];
  bit   mlock [NP];
  bit   rnd_periph = 1'b0;

  pad_cfg_sequencer #(.NUM_PADS(NP), .SETTLE_CYCLES(S)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o),
    .cfg_idx_i(cfg_idx_i), .cfg_wdata_i(cfg_wdata_i),
`ifdef PAD_CFG_LOCK_EN
    .cfg_lock_i(cfg_lock_i),
`endif
    .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
    .busy_o(busy_o), .periph_oen_i(periph_oen_i),
    .pad_oen_o(pad_oen_o), .pad_drv_o(pad_drv_o),
    .pad_puen_o(pad_puen_o), .pad_slw_o(pad_slw_o),
    .pad_smt_o(pad_smt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag, int iso_idx,
                           bit done, bit err, bit busy, bit gnt);
    logic [NP-1:0]   eo, epu, esl, esm;
    logic [2*NP-1:0] edrv;
    for (int k = 0; k < NP; k++) begin
      edrv[2*k +: 2] = mcfg[k][5:4];
      esm[k] = mcfg[k][3];
      esl[k] = mcfg[k][2];
      epu[k] = mcfg[k][1];
      eo[k]  = (k == iso_idx || !mcfg[k][0]) ? 1'b1 : periph_oen_i[k];
    end
    chk({tag, ".oen"},  64'(pad_oen_o),  64'(eo));
    chk({tag, ".drv"},  64'(pad_drv_o),  64'(edrv));
    chk({tag, ".puen"}, 64'(pad_puen_o), 64'(epu));
    chk({tag, ".slw"},  64'(pad_slw_o),  64'(esl));
    chk({tag, ".smt"},  64'(pad_smt_o),  64'(esm));
    chk({tag, ".done"}, 64'(cfg_done_o), 64'(done));
    chk({tag, ".err"},  64'(cfg_err_o),  64'(err));
    chk({tag, ".busy"}, 64'(busy_o),     64'(busy));
    chk({tag, ".gnt"},  64'(cfg_gnt_o),  64'(gnt));
  endtask

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      mcfg[k]  = '0;
      mlock[k] = 1'b0;
    end
  endtask

  task automatic next_periph();
    if (rnd_periph) periph_oen_i = NP'($urandom);
  endtask

  task automatic drive(int idx, logic [5:0] w, bit lk);
    cfg_req_i   = 1'b1;
    cfg_idx_i   = IW'(idx);
    cfg_wdata_i = w;
`ifdef PAD_CFG_LOCK_EN
    cfg_lock_i  = lk;
`endif
  endtask

  // Called at the negedge of the accept cycle with the request driven.
  task automatic xfer(int idx, logic [5:0] w, bit lk, bit chain,
                      int nidx, logic [5:0] nw, bit nlk, int rst_at);
    bit bad, same;
    bad = (idx >= NP);
`ifdef PAD_CFG_LOCK_EN
    if (!bad && mlock[idx]) bad = 1'b1;
`endif
    same = !bad && (mcfg[idx] == w);
    chk("accept.gnt", 64'(cfg_gnt_o), 64'd1);
    if (bad || same) begin
      @(negedge clk_i);
      check_all(bad ? "reject" : "noop", -1, same, bad, 1'b0, 1'b1);
      if (same && lk) mlock[idx] = 1'b1;
      cfg_req_i = 1'b0;
      next_periph();
      return;
    end
    for (int c = 1; c <= S + 3; c++) begin
      @(negedge clk_i);
      if (c == 2) mcfg[idx] = w;
      check_all("write", (c <= S + 1) ? idx : -1,
                c == S + 2, 1'b0, c <= S + 2, c == S + 3);
      if (c == rst_at) begin
        #1 rst_ni = 1'b0;
        #1 model_reset();
        cfg_req_i = 1'b0;
        check_all("midrst", -1, 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      if (c == 1) begin
        if (chain) drive(nidx, nw, nlk);
        else cfg_req_i = 1'b0;
      end
      next_periph();
    end
    if (lk) mlock[idx] = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    int idx;
    logic [5:0] w;
    bit lk;
    model_reset();
    periph_oen_i = NP'(20'h5A5A0) & ~(NP'(1) << 3);

    // Asynchronous reset, asserted away from any clock edge
    #13 rst_ni = 1'b0;
    #1 check_all("reset", -1, 1'b0, 1'b0, 1'b0, 1'b1);
    release_reset();

    drive(3, 6'b10_0_1_0_1, 1'b0);
    xfer(3, 6'b10_0_1_0_1, 1'b0, 1'b0, 0, '0, 1'b0, 0);

    drive(NP, 6'b11_1_1_1_1, 1'b0);
    xfer(NP, 6'b11_1_1_1_1, 1'b0, 1'b0, 0, '0, 1'b0, 0);

    drive(3, 6'b10_0_1_0_1, 1'b0);
    xfer(3, 6'b10_0_1_0_1, 1'b0, 1'b0, 0, '0, 1'b0, 0);

    // Back-to-back: second request held through the first sequence
    drive(3, 6'b01_1_0_1_1, 1'b0);
    xfer(3, 6'b01_1_0_1_1, 1'b0, 1'b1, 3, 6'b11_0_0_0_1, 1'b0, 0);
    xfer(3, 6'b11_0_0_0_1, 1'b0, 1'b0, 0, '0, 1'b0, 3);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      check_all("postrst", -1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk_i);
    end

`ifdef PAD_CFG_LOCK_EN
    drive(5, 6'b01_0_1_1_1, 1'b1);
    xfer(5, 6'b01_0_1_1_1, 1'b1, 1'b0, 0, '0, 1'b0, 0);
    drive(5, 6'b10_1_0_0_1, 1'b0);
    xfer(5, 6'b10_1_0_0_1, 1'b0, 1'b0, 0, '0, 1'b0, 0);
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    model_reset();
    release_reset();
    drive(5, 6'b10_1_0_0_1, 1'b0);
    xfer(5, 6'b10_1_0_0_1, 1'b0, 1'b0, 0, '0, 1'b0, 0);
`endif

    rnd_periph = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idx = NP + $urandom_range(0, 31 - NP);
      else idx = $urandom_range(0, NP - 1);
      w = 6'($urandom);
      if (idx < NP && $urandom_range(0, 3) == 0) w = mcfg[idx];
      lk = 1'b0;
`ifdef PAD_CFG_LOCK_EN
      lk = ($urandom_range(0, 7) == 0);
`endif
      drive(idx, w, lk);
      xfer(idx, w, lk, 1'b0, 0, '0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
